fta_scratchpad_resp: RTL and testbench

- Target-side responder for the 128-bit fta bus; the counterpart to a bus master that issues single-cycle request strobes and waits for ack or rty.
- Implements a 128-bit-wide line-organised scratchpad RAM with byte-lane writes and a fixed, parameterised response latency.
- Accepts one transaction at a time and asks the master to retry any request that arrives while busy.
- Sits on the core's data bus alongside other responders; it claims an access only when the address falls in its window.

---
 rtl/fta_scratchpad_resp_if.sv | 27 ++
 rtl/fta_scratchpad_resp.sv | 180 ++++++++++++++++++
 tb/tb_fta_scratchpad_resp.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fta_scratchpad_resp_if.sv
// Request/response bundle for the 128-bit fta bus between one master and one responder.
// Only the fields this responder consumes or drives are carried.
interface fta_scratchpad_resp_if;
   logic         req_cyc;
   logic         req_stb;
   logic         req_we;
   logic [15:0]  req_sel;
   logic [31:0]  req_adr;
   logic [127:0] req_dat;
   logic [7:0]   req_tid;

   logic         resp_ack;
   logic         resp_rty;
   logic [127:0] resp_dat;
   logic [7:0]   resp_tid;
   logic [31:0]  resp_adr;

   modport master (
      output req_cyc, req_stb, req_we, req_sel, req_adr, req_dat, req_tid,
      input  resp_ack, resp_rty, resp_dat, resp_tid, resp_adr
   );

   modport slave (
      input  req_cyc, req_stb, req_we, req_sel, req_adr, req_dat, req_tid,
      output resp_ack, resp_rty, resp_dat, resp_tid, resp_adr
   );
endinterface

// File: rtl/fta_scratchpad_resp.sv
// Scratchpad RAM responder on the 128-bit fta bus: one transaction at a time, fixed ack latency,
// byte-lane writes, retry for requests that arrive while a transaction is pending.
module fta_scratchpad_resp #(
   parameter logic [31:0] BASE       = 32'h0000_0000,
   parameter logic [31:0] MASK       = 32'hFFFF_C000,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned LATENCY    = 2,
   parameter bit          ACK_WRITES = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   fta_scratchpad_resp_if.slave  ftas,
   output logic                  busy_o
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           lat_we_q;
   logic [31:0]    lat_adr_q;
   logic [7:0]     lat_tid_q;

   logic [127:0]   mem [DEPTH];

   logic           ack_q, ack_d;
   logic           rty_q, rty_d;
   logic [127:0]   dat_q, dat_d;
   logic [7:0]     tid_q, tid_d;
   logic [31:0]    adr_q, adr_d;

   // One-entry holding slot for an rty that collided with an ack
   logic           hold_v_q, hold_v_d;
   logic [7:0]     hold_tid_q, hold_tid_d;
   logic [31:0]    hold_adr_q, hold_adr_d;

   logic           req_hit;
   logic           accept;
   logic           rty_new;
   logic           ack_fire;
   logic [IdxW-1:0] req_idx;
   logic           cur_we;
   logic [31:0]    cur_adr;
   logic [7:0]     cur_tid;
   logic [IdxW-1:0] cur_idx;

   assign req_hit = ftas.req_cyc && ftas.req_stb && ((ftas.req_adr & MASK) == BASE);
   assign req_idx = ftas.req_adr[4 +: IdxW];
   assign accept  = req_hit && (state_q == StIdle);
   assign rty_new = req_hit && (state_q != StIdle);

   // With LATENCY=1 the response is built straight from the live request
   always_comb begin
      if (state_q == StIdle) begin
         cur_we  = ftas.req_we;
         cur_adr = ftas.req_adr;
         cur_tid = ftas.req_tid;
      end else begin
         cur_we  = lat_we_q;
         cur_adr = lat_adr_q;
         cur_tid = lat_tid_q;
      end
      cur_idx = cur_adr[4 +: IdxW];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d = 4'(LATENCY - 1);
               if (LATENCY <= 1) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign ack_fire = (state_d == StResp) && (!cur_we || ACK_WRITES);

   always_comb begin
      ack_d      = 1'b0;
      rty_d      = 1'b0;
      dat_d      = '0;
      tid_d      = '0;
      adr_d      = '0;
      hold_v_d   = hold_v_q;
      hold_tid_d = hold_tid_q;
      hold_adr_d = hold_adr_q;
      if (ack_fire) begin
         ack_d = 1'b1;
         dat_d = cur_we ? '0 : mem[cur_idx];
         tid_d = cur_tid;
         adr_d = cur_adr;
         if (rty_new) begin
            hold_v_d   = 1'b1;
            hold_tid_d = ftas.req_tid;
            hold_adr_d = ftas.req_adr;
         end
      end else if (hold_v_q) begin
         rty_d      = 1'b1;
         tid_d      = hold_tid_q;
         adr_d      = hold_adr_q;
         hold_v_d   = rty_new;
         hold_tid_d = ftas.req_tid;
         hold_adr_d = ftas.req_adr;
      end else if (rty_new) begin
         rty_d = 1'b1;
         tid_d = ftas.req_tid;
         adr_d = ftas.req_adr;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         lat_we_q   <= 1'b0;
         lat_adr_q  <= '0;
         lat_tid_q  <= '0;
         ack_q      <= 1'b0;
         rty_q      <= 1'b0;
         dat_q      <= '0;
         tid_q      <= '0;
         adr_q      <= '0;
         hold_v_q   <= 1'b0;
         hold_tid_q <= '0;
         hold_adr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         if (accept) begin
            lat_we_q  <= ftas.req_we;
            lat_adr_q <= ftas.req_adr;
            lat_tid_q <= ftas.req_tid;
         end
         ack_q      <= ack_d;
         rty_q      <= rty_d;
         dat_q      <= dat_d;
         tid_q      <= tid_d;
         adr_q      <= adr_d;
         hold_v_q   <= hold_v_d;
         hold_tid_q <= hold_tid_d;
         hold_adr_q <= hold_adr_d;
      end
   end

   // Memory is not cleared by reset, but a write sampled during reset is dropped
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept && ftas.req_we) begin
         for (int i = 0; i < 16; i++) begin
            if (ftas.req_sel[i]) begin
               mem[req_idx][8*i +: 8] <= ftas.req_dat[8*i +: 8];
            end
         end
      end
   end

   assign ftas.resp_ack = ack_q;
   assign ftas.resp_rty = rty_q;
   assign ftas.resp_dat = dat_q;
   assign ftas.resp_tid = tid_q;
   assign ftas.resp_adr = adr_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_fta_scratchpad_resp.sv
// Directed bench for fta_scratchpad_resp: instance A at LATENCY=2 with write acks,
// instance B at LATENCY=1 with silent writes.
module tb_fta_scratchpad_resp;

   logic clk;
   logic rst_a;
   logic rst_b;
   logic busy_a;
   logic busy_b;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
   localparam logic [127:0] LANES = {{14{8'hAA}}, 16'h1122};

   fta_scratchpad_resp_if bus_a ();
   fta_scratchpad_resp_if bus_b ();

   fta_scratchpad_resp #(
      .BASE       (32'h0000_0000),
      .MASK       (32'hFFFF_C000),
      .DEPTH      (1024),
      .LATENCY    (2),
      .ACK_WRITES (1'b1)
   ) u_dut_a (
      .clk_i  (clk),
      .rst_i  (rst_a),
      .ftas   (bus_a),
      .busy_o (busy_a)
   );

   fta_scratchpad_resp #(
      .BASE       (32'h0000_0000),
      .MASK       (32'hFFFF_C000),
      .DEPTH      (1024),
      .LATENCY    (1),
      .ACK_WRITES (1'b0)
   ) u_dut_b (
      .clk_i  (clk),
      .rst_i  (rst_b),
      .ftas   (bus_b),
      .busy_o (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic a_drive(input logic we, input logic [15:0] sel, input logic [31:0] adr,
                          input logic [127:0] dat, input logic [7:0] tid);
      bus_a.req_cyc = 1'b1;
      bus_a.req_stb = 1'b1;
      bus_a.req_we  = we;
      bus_a.req_sel = sel;
      bus_a.req_adr = adr;
      bus_a.req_dat = dat;
      bus_a.req_tid = tid;
   endtask

   task automatic a_clear();
      bus_a.req_cyc = 1'b0;
      bus_a.req_stb = 1'b0;
      bus_a.req_we  = 1'b0;
      bus_a.req_sel = '0;
      bus_a.req_adr = '0;
      bus_a.req_dat = '0;
      bus_a.req_tid = '0;
   endtask

   task automatic b_drive(input logic we, input logic [15:0] sel, input logic [31:0] adr,
                          input logic [127:0] dat, input logic [7:0] tid);
      bus_b.req_cyc = 1'b1;
      bus_b.req_stb = 1'b1;
      bus_b.req_we  = we;
      bus_b.req_sel = sel;
      bus_b.req_adr = adr;
      bus_b.req_dat = dat;
      bus_b.req_tid = tid;
   endtask

   task automatic b_clear();
      bus_b.req_cyc = 1'b0;
      bus_b.req_stb = 1'b0;
      bus_b.req_we  = 1'b0;
      bus_b.req_sel = '0;
      bus_b.req_adr = '0;
      bus_b.req_dat = '0;
      bus_b.req_tid = '0;
   endtask

   // Full transaction on A: request at T, ack expected at T+2, idle again at T+3
   task automatic a_xact(input string tag, input logic we, input logic [15:0] sel,
                         input logic [31:0] adr, input logic [127:0] dat, input logic [7:0] tid,
                         input logic [127:0] exp_dat);
      a_drive(we, sel, adr, dat, tid);
      step();
      a_clear();
      check({tag, "_busy1"}, busy_a, 1);
      check({tag, "_noack1"}, bus_a.resp_ack, 0);
      step();
      check({tag, "_ack"}, bus_a.resp_ack, 1);
      check({tag, "_rty"}, bus_a.resp_rty, 0);
      check({tag, "_tid"}, bus_a.resp_tid, tid);
      check({tag, "_adr"}, bus_a.resp_adr, adr);
      check({tag, "_dat"}, bus_a.resp_dat, exp_dat);
      step();
      check({tag, "_ackoff"}, bus_a.resp_ack, 0);
      check({tag, "_idle"}, busy_a, 0);
   endtask

   logic seen;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      a_clear();
      b_clear();
      repeat (3) step();
      rst_a = 1'b0;
      rst_b = 1'b0;
      step();

      check("rst_ack", bus_a.resp_ack, 0);
      check("rst_rty", bus_a.resp_rty, 0);
      check("rst_dat", bus_a.resp_dat, 0);
      check("rst_tid", bus_a.resp_tid, 0);
      check("rst_adr", bus_a.resp_adr, 0);
      check("rst_busy", busy_a, 0);

      // Write then read back
      a_xact("wr", 1'b1, 16'hFFFF, 32'h0000_0010, D1, 8'd5, '0);
      a_xact("rd", 1'b0, 16'h0000, 32'h0000_0010, '0, 8'd6, D1);

      // Byte lanes
      a_xact("wr_aa", 1'b1, 16'hFFFF, 32'h0000_0020, {16{8'hAA}}, 8'd8, '0);
      a_xact("wr_lane", 1'b1, 16'h0003, 32'h0000_0020, 128'h1122, 8'd9, '0);
      a_xact("rd_lane", 1'b0, 16'h0000, 32'h0000_0020, '0, 8'd10, LANES);
      a_xact("wr_sel0", 1'b1, 16'h0000, 32'h0000_0020, '1, 8'd11, '0);
      a_xact("rd_sel0", 1'b0, 16'h0000, 32'h0000_0020, '0, 8'd12, LANES);

      // Retry colliding with ack: rty for tid 2 slips to T+3
      a_drive(1'b0, 16'h0000, 32'h0000_0010, '0, 8'd1);
      step();
      a_drive(1'b1, 16'hFFFF, 32'h0000_0020, '0, 8'd2);
      check("col_busy", busy_a, 1);
      check("col_noack", bus_a.resp_ack, 0);
      check("col_nor1", bus_a.resp_rty, 0);
      step();
      a_clear();
      check("col_ack", bus_a.resp_ack, 1);
      check("col_ack_tid", bus_a.resp_tid, 1);
      check("col_ack_dat", bus_a.resp_dat, D1);
      check("col_nor2", bus_a.resp_rty, 0);
      step();
      check("col_rty", bus_a.resp_rty, 1);
      check("col_rty_noack", bus_a.resp_ack, 0);
      check("col_rty_tid", bus_a.resp_tid, 2);
      check("col_rty_adr", bus_a.resp_adr, 32'h0000_0020);
      check("col_rty_dat", bus_a.resp_dat, 0);
      step();
      check("col_rty_off", bus_a.resp_rty, 0);
      check("col_idle", busy_a, 0);
      a_xact("col_mem", 1'b0, 16'h0000, 32'h0000_0020, '0, 8'd13, LANES);

      // Retry during RESP: rty lands the next cycle, no collision
      a_drive(1'b0, 16'h0000, 32'h0000_0010, '0, 8'd14);
      step();
      a_clear();
      step();
      a_drive(1'b1, 16'hFFFF, 32'h0000_0010, '0, 8'd3);
      check("rr_ack", bus_a.resp_ack, 1);
      step();
      a_clear();
      check("rr_rty", bus_a.resp_rty, 1);
      check("rr_tid", bus_a.resp_tid, 3);
      check("rr_adr", bus_a.resp_adr, 32'h0000_0010);
      check("rr_noack", bus_a.resp_ack, 0);
      step();
      check("rr_off", bus_a.resp_rty, 0);
      a_xact("rr_mem", 1'b0, 16'h0000, 32'h0000_0010, '0, 8'd15, D1);

      // Window miss; the write would alias line 1 if the compare were dropped
      a_drive(1'b1, 16'hFFFF, 32'h0001_0010, '0, 8'd4);
      step();
      a_clear();
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen = seen | bus_a.resp_ack | bus_a.resp_rty | busy_a;
         step();
      end
      check("miss_quiet", seen, 0);
      a_xact("miss_mem", 1'b0, 16'h0000, 32'h0000_0010, '0, 8'd16, D1);

      // Reset mid-operation
      a_drive(1'b0, 16'h0000, 32'h0000_0010, '0, 8'd7);
      step();
      a_clear();
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      check("mid_ack", bus_a.resp_ack, 0);
      check("mid_rty", bus_a.resp_rty, 0);
      check("mid_dat", bus_a.resp_dat, 0);
      check("mid_tid", bus_a.resp_tid, 0);
      check("mid_adr", bus_a.resp_adr, 0);
      check("mid_busy", busy_a, 0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         seen = seen | bus_a.resp_ack | bus_a.resp_rty | busy_a;
      end
      check("mid_quiet", seen, 0);

      // Write sampled while in reset is dropped
      a_drive(1'b1, 16'hFFFF, 32'h0000_0010, '0, 8'd17);
      rst_a = 1'b1;
      step();
      a_clear();
      rst_a = 1'b0;
      step();
      a_xact("rst_wr", 1'b0, 16'h0000, 32'h0000_0010, '0, 8'd18, D1);

      // Instance B: silent write, one busy cycle, then LATENCY=1 read
      b_drive(1'b1, 16'hFFFF, 32'h0000_0030, D2, 8'd3);
      step();
      b_clear();
      check("b_wr_busy", busy_b, 1);
      check("b_wr_noack", bus_b.resp_ack, 0);
      step();
      check("b_wr_idle", busy_b, 0);
      check("b_wr_noack2", bus_b.resp_ack, 0);
      b_drive(1'b0, 16'h0000, 32'h0000_0030, '0, 8'd4);
      step();
      b_clear();
      check("b_rd_ack", bus_b.resp_ack, 1);
      check("b_rd_tid", bus_b.resp_tid, 4);
      check("b_rd_dat", bus_b.resp_dat, D2);
      check("b_rd_adr", bus_b.resp_adr, 32'h0000_0030);
      step();
      check("b_rd_off", bus_b.resp_ack, 0);
      check("b_rd_idle", busy_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
